// File: rtl/merge_pass_sched_pkg.sv
// Shared types for the range-sorter merge-pass scheduler: command struct,
// scheduler states and default sizing.
package merge_pass_sched_pkg;

   localparam int P_BANK_ADDR_WIDTH = 10;
   localparam int P_LEN_W           = P_BANK_ADDR_WIDTH + 2;
   localparam int P_RUN_INIT        = 16;

   typedef struct packed {
      logic [P_LEN_W-1:0] a_base;
      logic [P_LEN_W-1:0] a_len;
      logic [P_LEN_W-1:0] b_base;
      logic [P_LEN_W-1:0] b_len;
      logic [P_LEN_W-1:0] dst_base;
      logic               src_sel;
   } merge_cmd_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE    = 3'd1,
      WAIT     = 3'd2,
      PASS_END = 3'd3,
      DONE     = 3'd4
   } merge_sched_state_t;

   function automatic logic [P_LEN_W-1:0] min_len(input logic [P_LEN_W-1:0] a,
                                                  input logic [P_LEN_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/merge_cmd_gen.sv
// Combinational merge-command builder: turns the current run base, run width
// and pair count into the A/B run descriptors of one merge command.
module merge_cmd_gen
   import merge_pass_sched_pkg::*;
(
   input  logic [P_LEN_W-1:0] i_base,
   input  logic [P_LEN_W-1:0] i_w,
   input  logic [P_LEN_W-1:0] i_n,
   input  logic               i_src,
   output merge_cmd_t         o_cmd
);

   logic [P_LEN_W-1:0] w_rem_a;
   logic [P_LEN_W-1:0] w_b_base;
   logic [P_LEN_W-1:0] w_rem_b;

   assign w_rem_a  = i_n - i_base;
   assign w_b_base = i_base + i_w;
   assign w_rem_b  = i_n - w_b_base;

   // Run B is empty when the tail of the bank holds only a partial run A.
   always_comb begin
      o_cmd.a_base   = i_base;
      o_cmd.a_len    = min_len(i_w, w_rem_a);
      o_cmd.b_base   = w_b_base;
      o_cmd.b_len    = (i_n > w_b_base) ? min_len(i_w, w_rem_b) : {P_LEN_W{1'b0}};
      o_cmd.dst_base = i_base;
      o_cmd.src_sel  = i_src;
   end

endmodule

// File: rtl/merge_pass_sched.sv
// Ping-pong merge-pass scheduler: issues one merge command per run pair,
// waits for write-back, then swaps banks and doubles the run width.
module merge_pass_sched
   import merge_pass_sched_pkg::*;
#(
   parameter int BANK_ADDR_WIDTH = P_BANK_ADDR_WIDTH,
   parameter int RUN_INIT        = P_RUN_INIT,
   parameter int LEN_W           = BANK_ADDR_WIDTH + 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_in,
   input  logic [LEN_W-1:0] total_pairs_in,
   output logic             cmd_valid_out,
   input  logic             cmd_ready_in,
   output logic [LEN_W-1:0] cmd_a_base_out,
   output logic [LEN_W-1:0] cmd_a_len_out,
   output logic [LEN_W-1:0] cmd_b_base_out,
   output logic [LEN_W-1:0] cmd_b_len_out,
   output logic [LEN_W-1:0] cmd_dst_base_out,
   output logic             src_sel_out,
   input  logic             merge_ack_in,
   output logic [LEN_W-1:0] width_out,
   output logic             pass_done_out,
   output logic             merge_done_out,
   output logic             result_bank_out,
   output logic             busy_out
);

   localparam logic [LEN_W-1:0] L_RUN_INIT = LEN_W'(RUN_INIT);
   localparam logic [LEN_W-1:0] L_ZERO     = {LEN_W{1'b0}};

   merge_sched_state_t r_state, w_state_nxt;
   logic [LEN_W-1:0]   r_n, r_w, r_base;
   logic [LEN_W-1:0]   w_n_nxt, w_w_nxt, w_base_nxt;
   logic [LEN_W-1:0]   w_base_adv, w_w_dbl;
   logic               r_src, w_src_nxt;
   logic               r_result_bank, w_result_bank_nxt;
   logic               w_issue;
   merge_cmd_t         w_cmd;

   assign w_base_adv = r_base + {r_w[LEN_W-2:0], 1'b0};
   assign w_w_dbl    = {r_w[LEN_W-2:0], 1'b0};

   merge_cmd_gen u_cmd_gen (
      .i_base (P_LEN_W'(r_base)),
      .i_w    (P_LEN_W'(r_w)),
      .i_n    (P_LEN_W'(r_n)),
      .i_src  (r_src),
      .o_cmd  (w_cmd)
   );

   // State and pass counters; reset abandons any in-flight command.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_n           <= L_ZERO;
         r_w           <= L_RUN_INIT;
         r_base        <= L_ZERO;
         r_src         <= 1'b0;
         r_result_bank <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_n           <= w_n_nxt;
         r_w           <= w_w_nxt;
         r_base        <= w_base_nxt;
         r_src         <= w_src_nxt;
         r_result_bank <= w_result_bank_nxt;
      end
   end

   // Next-state and counter update.
   always_comb begin
      w_state_nxt       = r_state;
      w_n_nxt           = r_n;
      w_w_nxt           = r_w;
      w_base_nxt        = r_base;
      w_src_nxt         = r_src;
      w_result_bank_nxt = r_result_bank;
      case (r_state)
         IDLE, DONE: begin
            if (start_in) begin
               w_n_nxt           = total_pairs_in;
               w_w_nxt           = L_RUN_INIT;
               w_base_nxt        = L_ZERO;
               w_src_nxt         = 1'b0;
               w_result_bank_nxt = 1'b0;
               w_state_nxt       = (total_pairs_in <= L_RUN_INIT) ? DONE : ISSUE;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ISSUE: begin
            if (cmd_ready_in) begin
               w_state_nxt = WAIT;
            end else begin
               w_state_nxt = ISSUE;
            end
         end
         WAIT: begin
            if (merge_ack_in) begin
               w_base_nxt  = w_base_adv;
               w_state_nxt = (w_base_adv < r_n) ? ISSUE : PASS_END;
            end else begin
               w_state_nxt = WAIT;
            end
         end
         PASS_END: begin
            w_src_nxt  = ~r_src;
            w_w_nxt    = w_w_dbl;
            w_base_nxt = L_ZERO;
            if (w_w_dbl >= r_n) begin
               w_result_bank_nxt = ~r_src;
               w_state_nxt       = DONE;
            end else begin
               w_state_nxt = ISSUE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Command fields are only driven while offered so idle outputs read zero.
   assign w_issue          = (r_state == ISSUE);
   assign cmd_valid_out    = w_issue;
   assign cmd_a_base_out   = w_issue ? LEN_W'(w_cmd.a_base)   : L_ZERO;
   assign cmd_a_len_out    = w_issue ? LEN_W'(w_cmd.a_len)    : L_ZERO;
   assign cmd_b_base_out   = w_issue ? LEN_W'(w_cmd.b_base)   : L_ZERO;
   assign cmd_b_len_out    = w_issue ? LEN_W'(w_cmd.b_len)    : L_ZERO;
   assign cmd_dst_base_out = w_issue ? LEN_W'(w_cmd.dst_base) : L_ZERO;
   assign src_sel_out      = w_cmd.src_sel;
   assign width_out        = r_w;
   assign pass_done_out    = (r_state == PASS_END);
   assign merge_done_out   = (r_state == DONE);
   assign result_bank_out  = r_result_bank;
   assign busy_out         = (r_state == ISSUE) || (r_state == WAIT) || (r_state == PASS_END);

endmodule

// File: tb/tb_merge_pass_sched.sv
// Directed plus randomized bench for merge_pass_sched; expected commands come
// from a per-pass loop model of the merge schedule.
module tb_merge_pass_sched;

   localparam int LEN_W = 12;
   localparam int RUN   = 16;

   logic             clock = 1'b0;
   logic             reset, start_in, cmd_ready_in, merge_ack_in;
   logic [LEN_W-1:0] total_pairs_in;
   logic             cmd_valid_out, src_sel_out, pass_done_out, merge_done_out;
   logic             result_bank_out, busy_out;
   logic [LEN_W-1:0] cmd_a_base_out, cmd_a_len_out, cmd_b_base_out, cmd_b_len_out;
   logic [LEN_W-1:0] cmd_dst_base_out, width_out;

   int n_checks = 0;
   int n_fail   = 0;
   int pd_cnt   = 0;

   int q_ab[$], q_al[$], q_bb[$], q_bl[$], q_src[$], q_w[$];
   int exp_passes, exp_bank, exp_final_w;

   merge_pass_sched dut (
      .clock            (clock),
      .reset            (reset),
      .start_in         (start_in),
      .total_pairs_in   (total_pairs_in),
      .cmd_valid_out    (cmd_valid_out),
      .cmd_ready_in     (cmd_ready_in),
      .cmd_a_base_out   (cmd_a_base_out),
      .cmd_a_len_out    (cmd_a_len_out),
      .cmd_b_base_out   (cmd_b_base_out),
      .cmd_b_len_out    (cmd_b_len_out),
      .cmd_dst_base_out (cmd_dst_base_out),
      .src_sel_out      (src_sel_out),
      .merge_ack_in     (merge_ack_in),
      .width_out        (width_out),
      .pass_done_out    (pass_done_out),
      .merge_done_out   (merge_done_out),
      .result_bank_out  (result_bank_out),
      .busy_out         (busy_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (pass_done_out) pd_cnt++;
   endtask

   // Schedule model: every pass pairs adjacent runs of width w until one run covers n.
   function automatic void build_model(input int n);
      int w, src;
      q_ab.delete(); q_al.delete(); q_bb.delete(); q_bl.delete(); q_src.delete(); q_w.delete();
      w = RUN; src = 0; exp_passes = 0;
      while (w < n) begin
         for (int base = 0; base < n; base += 2 * w) begin
            q_ab.push_back(base);
            q_al.push_back((n - base < w) ? n - base : w);
            q_bb.push_back(base + w);
            q_bl.push_back((n > base + w) ? ((n - base - w < w) ? n - base - w : w) : 0);
            q_src.push_back(src);
            q_w.push_back(w);
         end
         exp_passes++;
         src = 1 - src;
         w = 2 * w;
      end
      exp_bank    = src;
      exp_final_w = w;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, cmd_valid_out, 0);
      chk({tag, "_busy"}, busy_out, 0);
      chk({tag, "_done"}, merge_done_out, 0);
      chk({tag, "_pd"}, pass_done_out, 0);
      chk({tag, "_bank"}, result_bank_out, 0);
      chk({tag, "_src"}, src_sel_out, 0);
      chk({tag, "_width"}, width_out, RUN);
      chk({tag, "_fields"}, {cmd_a_base_out, cmd_a_len_out, cmd_b_base_out}, 0);
   endtask

   task automatic chk_fields(input string tag, input int i);
      chk({tag, "_a_base"}, cmd_a_base_out, q_ab[i]);
      chk({tag, "_a_len"}, cmd_a_len_out, q_al[i]);
      chk({tag, "_b_base"}, cmd_b_base_out, q_bb[i]);
      chk({tag, "_b_len"}, cmd_b_len_out, q_bl[i]);
      chk({tag, "_dst"}, cmd_dst_base_out, q_ab[i]);
      chk({tag, "_src"}, src_sel_out, q_src[i]);
      chk({tag, "_width"}, width_out, q_w[i]);
   endtask

   task automatic run_merge(input int n, input int first_stall, input int max_stall,
                            input int ack_dly, input bit poke);
      int stall, d, k;
      build_model(n);
      pd_cnt = 0;
      total_pairs_in = LEN_W'(n);
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      total_pairs_in = '0;
      if (q_ab.size() == 0) begin
         chk("tiny_valid", cmd_valid_out, 0);
         chk("tiny_done", merge_done_out, 1);
         chk("tiny_bank", result_bank_out, 0);
         chk("tiny_busy", busy_out, 0);
         repeat (3) tick();
         chk("tiny_valid2", cmd_valid_out, 0);
         chk("tiny_pd", pd_cnt, 0);
         return;
      end
      chk("first_latency", cmd_valid_out, 1);
      for (int i = 0; i < q_ab.size(); i++) begin
         k = 0;
         while (!cmd_valid_out && k < 20) begin
            tick();
            k++;
         end
         chk("valid_timeout", cmd_valid_out, 1);
         if (!cmd_valid_out) return;
         chk_fields("cmd", i);
         stall = (i == 0 && first_stall >= 0) ? first_stall : $urandom_range(0, max_stall);
         cmd_ready_in = 1'b0;
         for (int s = 0; s < stall; s++) begin
            merge_ack_in = poke && (s == 0);
            start_in = poke && (s == 1);
            total_pairs_in = LEN_W'(5);
            tick();
            merge_ack_in = 1'b0;
            start_in = 1'b0;
            total_pairs_in = '0;
         end
         if (stall > 0) chk_fields("stall", i);
         cmd_ready_in = 1'b1;
         tick();
         cmd_ready_in = 1'b0;
         chk("accept_drop", cmd_valid_out, 0);
         d = (ack_dly >= 0) ? ack_dly : $urandom_range(0, 3);
         repeat (d) tick();
         merge_ack_in = 1'b1;
         tick();
         merge_ack_in = 1'b0;
      end
      k = 0;
      while (!merge_done_out && k < 10) begin
         tick();
         k++;
      end
      chk("done", merge_done_out, 1);
      chk("done_bank", result_bank_out, exp_bank);
      chk("done_busy", busy_out, 0);
      chk("pass_cnt", pd_cnt, exp_passes);
      chk("final_width", width_out, exp_final_w);
   endtask

   initial begin
      int accepts;
      reset = 1'b0; start_in = 1'b0; cmd_ready_in = 1'b0; merge_ack_in = 1'b0;
      total_pairs_in = '0;
      repeat (2) tick();
      chk_reset("por");
      reset = 1'b1;
      tick();

      run_merge(16, 0, 0, 1, 1'b0);
      run_merge(40, 0, 0, 1, 1'b0);
      run_merge(190, 0, 2, -1, 1'b0);
      run_merge(40, 5, 0, 1, 1'b1);

      // Reset while waiting on the first command of pass 2.
      total_pairs_in = LEN_W'(40);
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      cmd_ready_in = 1'b1;
      accepts = 0;
      for (int k = 0; k < 60 && accepts < 3; k++) begin
         if (cmd_valid_out) begin
            tick();
            accepts++;
            if (accepts < 3) begin
               tick();
               merge_ack_in = 1'b1;
               tick();
               merge_ack_in = 1'b0;
            end
         end else begin
            tick();
         end
      end
      cmd_ready_in = 1'b0;
      chk("mid_accepts", accepts, 3);
      chk("mid_busy", busy_out, 1);
      chk("mid_width", width_out, 32);
      reset = 1'b0;
      pd_cnt = 0;
      tick();
      reset = 1'b1;
      chk_reset("midrst");
      repeat (2) tick();
      chk("midrst_pd", pd_cnt, 0);
      run_merge(40, 0, 0, 1, 1'b0);

      run_merge(0, 0, 0, 0, 1'b0);
      run_merge(17, 0, 1, -1, 1'b1);
      run_merge(32, 0, 1, -1, 1'b0);
      run_merge(33, 2, 1, 0, 1'b1);
      for (int r = 0; r < 6; r++) begin
         run_merge($urandom_range(0, 300), -1, 3, -1, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
